johnson_ring_ctr: RTL

//  Parametrised N-bit shift-register counter; next generation of the fixed 5-bit Johnson counter.

---
 rtl/johnson_ring_ctr.sv | 100 ++++++++++
 1 files changed

// File: rtl/johnson_ring_ctr.sv
// N-bit shift-register counter that runs as a Johnson (period 2N) or one-hot ring (period N)
// sequencer, with up/down stepping, parallel load, illegal-state recovery and a sticky error flag.
module johnson_ring_ctr #(
  parameter int unsigned N = 5,
  localparam int unsigned IW = $clog2(2 * N)
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          en,
  input  logic          dir,
  input  logic          mode,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  Q,
  output logic [IW-1:0] idx,
  output logic          tc,
  output logic          err
);

  localparam logic [IW-1:0] JohnLast   = IW'(2 * N - 1);
  localparam logic [IW-1:0] RingLast   = IW'(N - 1);
  localparam logic [IW-1:0] JohnPeriod = IW'(2 * N);

  logic [N-1:0]  cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          err_q, err_d;
  logic [IW-1:0] ones, trans, ring_pos, last;
  logic          legal;

  function automatic logic [N-1:0] reset_pat(input logic m);
    return m ? N'(1) : '0;
  endfunction

  // Decode: population count, adjacent-bit transitions and highest set bit position.
  always_comb begin
    ones     = '0;
    trans    = '0;
    ring_pos = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (cnt_q[i]) begin
        ones     = ones + IW'(1);
        ring_pos = IW'(i);
      end
    end
    for (int i = 0; i < int'(N) - 1; i++) begin
      if (cnt_q[i] != cnt_q[i+1]) trans = trans + IW'(1);
    end

    if (mode_q) legal = (ones == IW'(1));
    else        legal = (trans <= IW'(1));

    // Johnson: ones filled from the LSB count up; ones parked at the MSB count from the top.
    if (!legal)                         idx = '0;
    else if (mode_q)                    idx = ring_pos;
    else if (cnt_q[0] || ones == '0)    idx = ones;
    else                                idx = JohnPeriod - ones;

    last = mode_q ? RingLast : JohnLast;
    tc   = en & legal & ~load & ~Reset & (mode == mode_q) &
           (dir ? (idx == '0) : (idx == last));
  end

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    err_d  = err_q;
    if (mode != mode_q) begin
      cnt_d  = reset_pat(mode);
      mode_d = mode;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && !legal) begin
      cnt_d = reset_pat(mode_q);
      err_d = 1'b1;
    end else if (en) begin
      case ({mode_q, dir})
        2'b00:   cnt_d = {cnt_q[N-2:0], ~cnt_q[N-1]};
        2'b01:   cnt_d = {~cnt_q[0], cnt_q[N-1:1]};
        2'b10:   cnt_d = {cnt_q[N-2:0], cnt_q[N-1]};
        default: cnt_d = {cnt_q[0], cnt_q[N-1:1]};
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      cnt_q  <= reset_pat(mode);
      mode_q <= mode;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      err_q  <= err_d;
    end
  end

  assign Q   = cnt_q;
  assign err = err_q;

endmodule
